// File: rtl/mem_io_arbiter.sv
// Shares the data-memory port and the LED/switch registers between the CPU load/store
// path and the UART loader, serving one access at a time with a one-cycle done pulse.
module mem_io_arbiter #(
    parameter logic [31:0] LED_ADDR    = 32'hFFFF_FC60,
    parameter logic [31:0] SWITCH_ADDR = 32'hFFFF_FC70,
    parameter int          LED_W       = 16
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iCpuReq,
    input  logic             iCpuWe,
    input  logic [31:0]      iCpuAddr,
    input  logic [31:0]      iCpuWdata,
    output logic             oCpuDone,
    output logic [31:0]      oCpuRdata,
    output logic             oCpuStall,
    input  logic             iUartReq,
    input  logic             iUartWe,
    input  logic [31:0]      iUartAddr,
    input  logic [31:0]      iUartWdata,
    output logic             oUartDone,
    output logic [31:0]      oUartRdata,
    output logic             oMemEn,
    output logic             oMemWe,
    output logic [31:0]      oMemAddr,
    output logic [31:0]      oMemWdata,
    input  logic [31:0]      iMemRdata,
    output logic [LED_W-1:0] oLedData,
    input  logic [15:0]      iSwitchData
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_UART = 1'b1;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_owner_q, last_owner_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic [31:0]      uart_rdata_q, uart_rdata_d;
    logic [LED_W-1:0] led_q, led_d;

    logic             is_io;
    logic             mem_issue;
    logic             grant_uart;
    logic             load_en;
    logic [31:0]      load_val;

    assign is_io     = (addr_q[31:10] == 22'h3FFFFF);
    assign mem_issue = (state_q == S_ISSUE) && !is_io;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        uart_rdata_d = uart_rdata_q;
        led_d        = led_q;
        grant_uart   = 1'b0;
        load_en      = 1'b0;
        load_val     = 32'h0;

        case (state_q)
            S_IDLE: begin
                if (iCpuReq || iUartReq) begin
                    // On a tie the requester that was not served last wins
                    grant_uart   = iUartReq && (!iCpuReq || (last_owner_q == OWNER_CPU));
                    owner_d      = grant_uart;
                    last_owner_d = grant_uart;
                    we_d         = grant_uart ? iUartWe    : iCpuWe;
                    addr_d       = grant_uart ? iUartAddr  : iCpuAddr;
                    wdata_d      = grant_uart ? iUartWdata : iCpuWdata;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!is_io) begin
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    state_d     = we_q ? S_RESP : S_WAIT;
                end else begin
                    if (we_q && (addr_q == LED_ADDR)) begin
                        led_d = wdata_q[LED_W-1:0];
                    end
                    if (!we_q) begin
                        load_en  = 1'b1;
                        load_val = (addr_q == SWITCH_ADDR) ?
                                   {{16{iSwitchData[15]}}, iSwitchData} : 32'h0;
                    end
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                load_en  = 1'b1;
                load_val = iMemRdata;
                state_d  = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Load data goes straight into the owner's read register so it is valid with done
        if (load_en) begin
            if (owner_q == OWNER_UART) begin
                uart_rdata_d = load_val;
            end else begin
                cpu_rdata_d = load_val;
            end
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWNER_CPU;
            last_owner_q <= OWNER_CPU;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            cpu_rdata_q  <= 32'h0;
            uart_rdata_q <= 32'h0;
            led_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            uart_rdata_q <= uart_rdata_d;
            led_q        <= led_d;
        end
    end

    // Address and write data hold their last issued values outside ISSUE
    assign oMemEn     = mem_issue;
    assign oMemWe     = mem_issue && we_q;
    assign oMemAddr   = mem_issue ? addr_q  : mem_addr_q;
    assign oMemWdata  = mem_issue ? wdata_q : mem_wdata_q;
    assign oCpuDone   = (state_q == S_RESP) && (owner_q == OWNER_CPU);
    assign oUartDone  = (state_q == S_RESP) && (owner_q == OWNER_UART);
    assign oCpuStall  = iCpuReq && !oCpuDone;
    assign oCpuRdata  = cpu_rdata_q;
    assign oUartRdata = uart_rdata_q;
    assign oLedData   = led_q;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Self-checking bench for mem_io_arbiter: fixed vector table, tie/reset sequences and
// randomized accesses compared against a transaction-level model of memory, LED and owners.
module tb_mem_io_arbiter;

    localparam logic [31:0] LED_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] SW_ADDR  = 32'hFFFF_FC70;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iCpuReq = 1'b0, iCpuWe = 1'b0;
    logic [31:0] iCpuAddr = 32'h0, iCpuWdata = 32'h0;
    logic        oCpuDone, oCpuStall;
    logic [31:0] oCpuRdata;
    logic        iUartReq = 1'b0, iUartWe = 1'b0;
    logic [31:0] iUartAddr = 32'h0, iUartWdata = 32'h0;
    logic        oUartDone;
    logic [31:0] oUartRdata;
    logic        oMemEn, oMemWe;
    logic [31:0] oMemAddr, oMemWdata;
    logic [31:0] iMemRdata;
    logic [15:0] oLedData;
    logic [15:0] iSwitchData = 16'h0;

    int vectors = 0;
    int miscompares = 0;

    mem_io_arbiter dut (
        .iClock(iClock), .iReset(iReset),
        .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuWdata(iCpuWdata),
        .oCpuDone(oCpuDone), .oCpuRdata(oCpuRdata), .oCpuStall(oCpuStall),
        .iUartReq(iUartReq), .iUartWe(iUartWe), .iUartAddr(iUartAddr), .iUartWdata(iUartWdata),
        .oUartDone(oUartDone), .oUartRdata(oUartRdata),
        .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWdata(oMemWdata),
        .iMemRdata(iMemRdata), .oLedData(oLedData), .iSwitchData(iSwitchData)
    );

    always #5 iClock = ~iClock;

    // Block-RAM stand-in: read data appears the cycle after the enable, garbage otherwise
    bit [31:0] ram [256];
    bit        pendValid;
    bit [31:0] pendData;
    always @(negedge iClock) begin
        if (oMemEn && oMemWe) ram[oMemAddr[9:2]] <= oMemWdata;
        pendValid <= oMemEn && !oMemWe;
        pendData  <= ram[oMemAddr[9:2]];
        iMemRdata <= pendValid ? pendData : $urandom();
    end

    // Reference model: word store, LED value, per-requester read data, who went last
    bit [31:0]   shadow [256];
    logic [15:0] ledM;
    logic [31:0] cpuRdM, uartRdM;
    bit          lastUartM;

    typedef struct {
        bit          uart;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        int          lat;
        logic [31:0] rdata;
        logic [15:0] led;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    function automatic bit isIo(input logic [31:0] a);
        return a[31:10] == 22'h3FFFFF;
    endfunction

    function automatic int latencyOf(input bit we, input logic [31:0] a);
        return (!isIo(a) && !we) ? 3 : 2;
    endfunction

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return {26'h0, 4'($urandom()), 2'b00};
            4:          return LED_ADDR;
            5:          return SW_ADDR;
            6:          return {22'h3FFFFF, 10'($urandom())};
            default:    return $urandom();
        endcase
    endfunction

    task automatic modelReset();
        ledM = 16'h0;
        cpuRdM = 32'h0;
        uartRdM = 32'h0;
        lastUartM = 1'b0;
    endtask

    task automatic modelStep(input bit u, input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [15:0] sw, output logic [31:0] rd, output logic [15:0] led);
        logic [31:0] loadVal;
        if (isIo(a)) loadVal = (a == SW_ADDR) ? 32'($signed(sw)) : 32'h0;
        else         loadVal = shadow[a[9:2]];
        if (we) begin
            if (!isIo(a))            shadow[a[9:2]] = wd;
            else if (a == LED_ADDR)  ledM = wd[15:0];
        end else if (u) begin
            uartRdM = loadVal;
        end else begin
            cpuRdM = loadVal;
        end
        lastUartM = u;
        rd  = u ? uartRdM : cpuRdM;
        led = ledM;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " cpuDone"},   32'(oCpuDone),  32'h0);
        checkOutput({tag, " uartDone"},  32'(oUartDone), 32'h0);
        checkOutput({tag, " cpuStall"},  32'(oCpuStall), 32'h0);
        checkOutput({tag, " memEn"},     32'(oMemEn),    32'h0);
        checkOutput({tag, " memWe"},     32'(oMemWe),    32'h0);
        checkOutput({tag, " memAddr"},   oMemAddr,       32'h0);
        checkOutput({tag, " memWdata"},  oMemWdata,      32'h0);
        checkOutput({tag, " cpuRdata"},  oCpuRdata,      32'h0);
        checkOutput({tag, " uartRdata"}, oUartRdata,     32'h0);
        checkOutput({tag, " led"},       32'(oLedData),  32'h0);
    endtask

    task automatic doReset(input string tag);
        iReset = 1'b1;
        iCpuReq = 1'b0;
        iUartReq = 1'b0;
        tick();
        tick();
        checkIdleZero(tag);
        iReset = 1'b0;
        modelReset();
    endtask

    // One access by a single requester, starting on the edge after the previous done
    task automatic doAccess(input string tag, input bit u, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [15:0] sw, input int expLat,
                            input logic [31:0] expRd, input logic [15:0] expLed);
        int cyc, memEnCount, stallCount, otherDone;
        bit done, stallAtDone;
        logic [31:0] rdAtDone;
        tick();
        iCpuReq  = !u;
        iUartReq = u;
        iCpuWe     = u ? 1'($urandom()) : we;
        iCpuAddr   = u ? $urandom()     : a;
        iCpuWdata  = u ? $urandom()     : wd;
        iUartWe    = u ? we : 1'($urandom());
        iUartAddr  = u ? a  : $urandom();
        iUartWdata = u ? wd : $urandom();
        iSwitchData = sw;
        #1;
        stallCount = (!u && oCpuStall) ? 1 : 0;
        cyc = 0; done = 0; memEnCount = 0; otherDone = 0; stallAtDone = 0; rdAtDone = 32'h0;
        while (!done && cyc < 8) begin
            tick();
            cyc++;
            if (oMemEn) begin
                memEnCount++;
                checkOutput({tag, " memEnCycle"}, cyc, 1);
                checkOutput({tag, " memWe"}, 32'(oMemWe), 32'(we));
                checkOutput({tag, " memAddr"}, oMemAddr, a);
                if (we) checkOutput({tag, " memWdata"}, oMemWdata, wd);
            end
            if (u ? oCpuDone : oUartDone) otherDone++;
            if (u ? oUartDone : oCpuDone) begin
                done = 1;
                rdAtDone = u ? oUartRdata : oCpuRdata;
                stallAtDone = oCpuStall;
            end else if (!u && oCpuStall) begin
                stallCount++;
            end
        end
        checkOutput({tag, " latency"}, done ? cyc : 0, expLat);
        checkOutput({tag, " memEnCount"}, memEnCount, isIo(a) ? 0 : 1);
        checkOutput({tag, " otherDone"}, otherDone, 0);
        checkOutput({tag, " rdata"}, rdAtDone, expRd);
        checkOutput({tag, " led"}, 32'(oLedData), 32'(expLed));
        if (!u) begin
            checkOutput({tag, " stallCycles"}, stallCount, expLat);
            checkOutput({tag, " stallAtDone"}, 32'(stallAtDone), 32'h0);
        end
    endtask

    // Both requesters raise requests in the same cycle and hold them until served
    task automatic doContest(input string tag, input bit cWe, input logic [31:0] cA, input logic [31:0] cWd,
                             input bit uWe, input logic [31:0] uA, input logic [31:0] uWd,
                             input logic [15:0] sw);
        int cyc, cpuDones, uartDones, firstUart, cpuCyc, uartCyc, extra;
        bit dropCpu, dropUart, expUartFirst;
        logic [31:0] expRd;
        logic [15:0] expLed;
        expUartFirst = !lastUartM;
        tick();
        iCpuReq = 1'b1;  iCpuWe = cWe;  iCpuAddr = cA;  iCpuWdata = cWd;
        iUartReq = 1'b1; iUartWe = uWe; iUartAddr = uA; iUartWdata = uWd;
        iSwitchData = sw;
        cyc = 0; cpuDones = 0; uartDones = 0; firstUart = -1; cpuCyc = -1; uartCyc = -2;
        dropCpu = 0; dropUart = 0; extra = 0;
        while ((cpuDones == 0 || uartDones == 0) && cyc < 12) begin
            tick();
            cyc++;
            if (dropCpu)  begin iCpuReq = 1'b0;  dropCpu = 0;  end
            if (dropUart) begin iUartReq = 1'b0; dropUart = 0; end
            if (oUartDone) begin
                uartDones++;
                uartCyc = cyc;
                if (firstUart < 0) firstUart = 1;
                modelStep(1'b1, uWe, uA, uWd, sw, expRd, expLed);
                checkOutput({tag, " uartRdata"}, oUartRdata, expRd);
                dropUart = 1;
            end
            if (oCpuDone) begin
                cpuDones++;
                cpuCyc = cyc;
                if (firstUart < 0) firstUart = 0;
                modelStep(1'b0, cWe, cA, cWd, sw, expRd, expLed);
                checkOutput({tag, " cpuRdata"}, oCpuRdata, expRd);
                dropCpu = 1;
            end
        end
        tick();
        iCpuReq = 1'b0;
        iUartReq = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            extra += int'(oCpuDone) + int'(oUartDone);
        end
        checkOutput({tag, " firstIsUart"}, firstUart, 32'(expUartFirst));
        checkOutput({tag, " cpuDones"}, cpuDones, 1);
        checkOutput({tag, " uartDones"}, uartDones, 1);
        checkOutput({tag, " sameCycleDone"}, 32'(cpuCyc == uartCyc), 32'h0);
        checkOutput({tag, " extraDones"}, extra, 0);
        checkOutput({tag, " led"}, 32'(oLedData), 32'(ledM));
    endtask

    task automatic applyStimulus(input int idx);
        logic [31:0] rd;
        logic [15:0] led;
        string tag;
        tag = $sformatf("vec%0d", idx);
        doAccess(tag, vecs[idx].uart, vecs[idx].we, vecs[idx].addr, vecs[idx].wdata, vecs[idx].sw,
                 vecs[idx].lat, vecs[idx].rdata, vecs[idx].led);
        modelStep(vecs[idx].uart, vecs[idx].we, vecs[idx].addr, vecs[idx].wdata, vecs[idx].sw, rd, led);
    endtask

    initial begin
        logic [31:0] a, wd, rd, a2, wd2;
        logic [15:0] sw, led;
        bit u, we, we2;
        int memEnSeen;

        // uart, we, addr, wdata, switches, latency, expected requester rdata, expected LED
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 2, 32'h0000_0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'h0000, 3, 32'hDEAD_BEEF, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FC60, 32'h0000_A5A5, 16'h0000, 2, 32'hDEAD_BEEF, 16'hA5A5};
        vecs[3]  = '{1'b0, 1'b0, 32'hFFFF_FC70, 32'h0000_0000, 16'h8001, 2, 32'hFFFF_8001, 16'hA5A5};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFF_FC80, 32'h0000_0000, 16'h1234, 2, 32'h0000_0000, 16'hA5A5};
        vecs[5]  = '{1'b1, 1'b1, 32'hFFFF_FC80, 32'h5A5A_0000, 16'h1234, 2, 32'h0000_0000, 16'hA5A5};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 16'h0000, 2, 32'h0000_0000, 16'hA5A5};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 16'h0000, 3, 32'hCAFE_F00D, 16'hA5A5};
        vecs[8]  = '{1'b0, 1'b0, 32'hFFFF_FC70, 32'h0000_0000, 16'h7FFE, 2, 32'h0000_7FFE, 16'hA5A5};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FC60, 32'hFFFF_1234, 16'h0000, 2, 32'h0000_7FFE, 16'h1234};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 16'h0000, 3, 32'hDEAD_BEEF, 16'h1234};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 16'h0000, 3, 32'hDEAD_BEEF, 16'h1234};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FC64, 32'h0000_0000, 16'h0000, 2, 32'hDEAD_BEEF, 16'h1234};

        $display("[TB] reset state");
        doReset("reset");

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) applyStimulus(i);

        $display("[TB] tie-break from reset");
        tick();
        iCpuReq = 1'b0;
        iUartReq = 1'b0;
        doReset("reset2");
        doContest("tie1", 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0000_0044, 32'h2222_2222, 16'h0);
        doContest("tie2", 1'b1, 32'h0000_0044, 32'h3333_3333, 1'b0, 32'h0000_0010, 32'h0, 16'h0);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 200; i++) begin
            sw = 16'($urandom());
            if ($urandom_range(0, 9) == 0) begin
                we = 1'($urandom()); a = randAddr(); wd = $urandom();
                we2 = 1'($urandom()); a2 = randAddr(); wd2 = $urandom();
                doContest($sformatf("randTie%0d", i), we, a, wd, we2, a2, wd2, sw);
            end else begin
                u = 1'($urandom()); we = 1'($urandom()); a = randAddr(); wd = $urandom();
                modelStep(u, we, a, wd, sw, rd, led);
                doAccess($sformatf("rand%0d", i), u, we, a, wd, sw, latencyOf(we, a), rd, led);
            end
        end

        $display("[TB] reset during memory load wait");
        tick();
        iCpuReq = 1'b0;
        iUartReq = 1'b0;
        tick();
        iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 32'h0000_0010; iCpuWdata = 32'h0;
        tick();
        checkOutput("abort issue memEn", 32'(oMemEn), 32'h1);
        tick();
        iReset = 1'b1;
        iCpuReq = 1'b0;
        #1;
        checkIdleZero("abort");
        memEnSeen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            memEnSeen += int'(oCpuDone) + int'(oMemEn);
        end
        checkOutput("abort quiet", memEnSeen, 0);
        iReset = 1'b0;
        modelReset();
        modelStep(1'b0, 1'b0, 32'h0000_0010, 32'h0, 16'h0, rd, led);
        doAccess("postReset", 1'b0, 1'b0, 32'h0000_0010, 32'h0, 16'h0, 3, rd, led);
        tick();
        iCpuReq = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
